serv_wb_mem_resp: RTL and testbench
===================================

// Module: serv_wb_mem_resp
// PURPOSE
//  Wishbone-classic memory responder for the SERV data/instruction bus; the target end of the
//  core's memory interface. Accepts word-addressed requests qualified by cyc, applies byte-lane
//  writes per sel, returns 32-bit read data with a single-cycle ack after programmable wait states.
//  Sits between the core bus (or arbiter) and a synchronous on-chip RAM.
// PARAMETERS
//  DEPTH   256  memory size in 32-bit words (power of 2, >=4)
//  AW      $clog2(DEPTH)  word-address width (derived)
//  LAT     0    wait states inserted between request sample and ack (0..15)
// PORTS
//  i_clk     in   1   clock, all logic on rising edge
//  i_rst     in   1   synchronous, active-high reset
//  i_wb_adr  in   32  byte address; [1:0] ignored, [AW+1:2] selects word, upper bits range-checked
//  i_wb_dat  in   32  write data
//  i_wb_sel  in   4   byte-lane enables, sel[n] -> dat[8n+7:8n]
//  i_wb_we   in   1   1=write, 0=read
//  i_wb_cyc  in   1   request valid; held by initiator until ack
//  o_wb_rdt  out  32  read data, valid in the ack cycle
//  o_wb_ack  out  1   one-cycle transfer acknowledge
//  o_oor     out  1   one-cycle pulse with ack when address is out of range
// BEHAVIOUR
//  Reset: state IDLE, o_wb_ack=0, o_oor=0, o_wb_rdt=0, wait counter=0. RAM contents NOT reset.
//  Reset asserted mid-transfer: transfer abandoned, no write committed, no ack.
//  FSM: IDLE -> (cyc & LAT==0) ACK | (cyc & LAT>0) WAIT;  WAIT: counter counts LAT-1..0,
//   -> ACK when counter==0;  ACK: o_wb_ack=1 for exactly one cycle -> IDLE.
//  Latency: ack in cycle LAT+1 after cyc first sampled high (cycle 0).
//  cyc dropped while in WAIT: return to IDLE, no write, no ack, counter cleared.
//  cyc assumed stable in ACK cycle; initiator drops cyc the cycle after ack. cyc still high in
//   the cycle after ack is a NEW request (back-to-back allowed, no turnaround state).
//  Address/data/sel/we captured in IDLE on request acceptance; later changes ignored.
//  Write: committed in the ACK cycle, only lanes with sel[n]=1 updated; sel=0000 acks, no change.
//  Read: RAM read issued so o_wb_rdt holds word in the ACK cycle; o_wb_rdt holds value until
//   next ack (initiator samples only on ack). Writes leave o_wb_rdt unchanged.
//  Range: i_wb_adr[31:AW+2] != 0 -> out of range: write dropped, read returns 0, o_oor=1 with ack.
//  Read-after-write same word, back-to-back: read returns newly written bytes.
//  No error/retry signalling; every accepted, non-abandoned request gets exactly one ack.
// STRUCTURE
//  Shared package serv_mem_pkg: FSM state encoding (IDLE/WAIT/ACK), LAT counter width (4),
//   lane count (4) constants.
//  Sub-module serv_ram_bank: DEPTH x 32 synchronous RAM with 4 byte write enables, 1-cycle
//   registered read; responder holds FSM, counter, capture regs and range check.
// TESTING
//  LAT=0, write 0xDEADBEEF sel=1111 adr 0x10, then read adr 0x10 -> ack 1 cycle after cyc, rdt=0xDEADBEEF.
//  Byte lanes: over 0xDEADBEEF write 0x000000AA sel=0001 then 0x00CC0000 sel=0100 -> read 0xDECCBEAA.
//  LAT=3: read request -> ack exactly in cycle 4, ack width 1; drop cyc in cycle 2 -> no ack, no write.
//  Out of range: DEPTH=256, write adr 0x400 -> ack+o_oor, word 0 unchanged; read adr 0x400 -> rdt=0, o_oor=1.
//  Back-to-back: cyc held high across 3 writes to words 0,1,2 -> three single-cycle acks, all written.
//  Reset during WAIT (LAT=5, i_rst at cycle 3) -> no ack, state IDLE, prior RAM contents intact.

Source files
------------

// File: rtl/serv_mem_pkg.sv
// -----------------------------------------------------------------------------
// serv_mem_pkg
// Shared definitions for the SERV Wishbone memory responder.
//   - state_t      : responder FSM encoding (IDLE / WAIT / ACK)
//   - CNT_W        : width of the wait-state counter (LAT is 0..15)
//   - LANES        : number of byte lanes on the 32-bit data bus
//   - DATA_W       : data bus width
//   - addr_oor()   : true when any byte-address bit above the word index is set
// -----------------------------------------------------------------------------
package serv_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2
  } state_t;

  localparam int CNT_W  = 4;
  localparam int LANES  = 4;
  localparam int DATA_W = 32;

  // A byte address is in range only when everything above the word index
  // (bits [31:aw+2]) is zero.
  function automatic logic addr_oor(input logic [31:0] adr, input int aw);
    return (adr >> (aw + 2)) != 32'd0;
  endfunction

endpackage

// File: rtl/serv_wb_mem_resp_if.sv
// -----------------------------------------------------------------------------
// serv_wb_mem_resp_if
// Wishbone-classic bus bundle between an initiator (SERV core or arbiter) and
// the memory responder.
//   i_wb_adr  32  byte address
//   i_wb_dat  32  write data
//   i_wb_sel   4  byte-lane enables
//   i_wb_we    1  1 = write, 0 = read
//   i_wb_cyc   1  request valid, held until ack
//   o_wb_rdt  32  read data, valid with ack
//   o_wb_ack   1  single-cycle transfer acknowledge
//   o_oor      1  out-of-range flag, pulses with ack
// Modports: master = initiator side, slave = responder side.
// -----------------------------------------------------------------------------
interface serv_wb_mem_resp_if;
  import serv_mem_pkg::*;

  logic [31:0]       i_wb_adr;
  logic [DATA_W-1:0] i_wb_dat;
  logic [LANES-1:0]  i_wb_sel;
  logic              i_wb_we;
  logic              i_wb_cyc;
  logic [DATA_W-1:0] o_wb_rdt;
  logic              o_wb_ack;
  logic              o_oor;

  modport master (
    output i_wb_adr, i_wb_dat, i_wb_sel, i_wb_we, i_wb_cyc,
    input  o_wb_rdt, o_wb_ack, o_oor
  );

  modport slave (
    input  i_wb_adr, i_wb_dat, i_wb_sel, i_wb_we, i_wb_cyc,
    output o_wb_rdt, o_wb_ack, o_oor
  );

endinterface

// File: rtl/serv_ram_bank.sv
// -----------------------------------------------------------------------------
// serv_ram_bank
// DEPTH x 32 synchronous RAM with per-byte write enables and a registered
// (one-cycle) read port. Contents are never reset.
// Ports:
//   i_clk    clock
//   i_we     write strobe
//   i_be     byte-lane enables for the write
//   i_waddr  write word address
//   i_wdat   write data
//   i_raddr  read word address (sampled every cycle)
//   o_rdat   read data, one cycle after i_raddr
// -----------------------------------------------------------------------------
module serv_ram_bank
  import serv_mem_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [LANES-1:0]  i_be,
  input  logic [AW-1:0]     i_waddr,
  input  logic [DATA_W-1:0] i_wdat,
  input  logic [AW-1:0]     i_raddr,
  output logic [DATA_W-1:0] o_rdat
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdat;

  // Write and read share the edge; a same-address collision returns the old
  // word, which the responder never relies on.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      for (int n = 0; n < LANES; n++) begin
        if (i_be[n]) r_mem[i_waddr][8*n +: 8] <= i_wdat[8*n +: 8];
      end
    end
    r_rdat <= r_mem[i_raddr];
  end

  assign o_rdat = r_rdat;

endmodule

// File: rtl/serv_wb_mem_resp.sv
// -----------------------------------------------------------------------------
// serv_wb_mem_resp
// Wishbone-classic memory responder for the SERV data/instruction bus.
// Accepts a word-addressed request qualified by cyc, waits LAT cycles, then
// acknowledges for exactly one cycle. Writes are committed in the ack cycle
// honouring sel; reads return the addressed word with the ack. Addresses with
// any bit set above the word index are out of range: writes are dropped, reads
// return zero, and o_oor pulses with the ack.
// Ports:
//   i_clk  clock, rising edge
//   i_rst  synchronous active-high reset
//   bus    serv_wb_mem_resp_if.slave (adr/dat/sel/we/cyc in, rdt/ack/oor out)
// Parameters:
//   DEPTH  memory size in 32-bit words (power of 2, >= 4)
//   LAT    wait states between request sample and ack (0..15)
// -----------------------------------------------------------------------------
module serv_wb_mem_resp
  import serv_mem_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int LAT   = 0
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  serv_wb_mem_resp_if.slave     bus
);

  localparam int AW     = $clog2(DEPTH);
  localparam int LAT_M1 = (LAT > 0) ? LAT - 1 : 0;

  state_t            r_state;
  state_t            w_next;
  logic [CNT_W-1:0]  r_cnt;

  logic [AW-1:0]     r_word;
  logic [DATA_W-1:0] r_dat;
  logic [LANES-1:0]  r_sel;
  logic              r_we;
  logic              r_oor;
  logic [DATA_W-1:0] r_rdt;

  logic              w_accept;
  logic              w_oor;
  logic              w_ack;
  logic              w_ram_we;
  logic [AW-1:0]     w_raddr;
  logic [DATA_W-1:0] w_ram_q;
  logic [DATA_W-1:0] w_rd_word;
  logic              w_unused;

  // Byte offset bits carry no meaning for a word-wide responder.
  assign w_unused = ^bus.i_wb_adr[1:0];

  assign w_accept = (r_state == ST_IDLE) && bus.i_wb_cyc;
  assign w_oor    = addr_oor(bus.i_wb_adr, AW);

  // ---------------------------------------------------------------- FSM state
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  // ----------------------------------------------------------- FSM next state
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (bus.i_wb_cyc) w_next = (LAT == 0) ? ST_ACK : ST_WAIT;
      end
      ST_WAIT: begin
        // Initiator gave up: abandon without writing or acking.
        if (!bus.i_wb_cyc)      w_next = ST_IDLE;
        else if (r_cnt == '0)   w_next = ST_ACK;
      end
      ST_ACK:  w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // ------------------------------------------------------------- FSM outputs
  // Reset in the ack cycle kills the ack as well as the write.
  always_comb begin
    w_ack           = (r_state == ST_ACK) && !i_rst;
    bus.o_wb_ack    = w_ack;
    bus.o_oor       = w_ack && r_oor;
    bus.o_wb_rdt    = (w_ack && !r_we) ? w_rd_word : r_rdt;
  end

  // ----------------------------------------------------- wait-state counter
  // Loaded with LAT-1 on acceptance so the last WAIT cycle is the one where
  // the counter reads zero; that gives ack in cycle LAT+1.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else begin
      case (r_state)
        ST_IDLE: r_cnt <= w_accept ? CNT_W'(LAT_M1) : '0;
        ST_WAIT: begin
          if (!bus.i_wb_cyc || r_cnt == '0) r_cnt <= '0;
          else                              r_cnt <= r_cnt - 1'b1;
        end
        default: r_cnt <= '0;
      endcase
    end
  end

  // ------------------------------------------------------ request capture
  // Only sampled on acceptance; anything the initiator changes later is
  // ignored until the next request.
  always_ff @(posedge i_clk) begin
    if (w_accept) begin
      r_word <= bus.i_wb_adr[AW+1:2];
      r_dat  <= bus.i_wb_dat;
      r_sel  <= bus.i_wb_sel;
      r_we   <= bus.i_wb_we;
      r_oor  <= w_oor;
    end
  end

  // --------------------------------------------------------- RAM access
  // In IDLE the read address comes straight from the bus so that with LAT=0
  // the registered RAM output is ready in the following (ACK) cycle. Later
  // cycles re-read the captured word, so the value seen in ACK also reflects
  // any write committed by the immediately preceding transfer.
  assign w_raddr  = (r_state == ST_IDLE) ? bus.i_wb_adr[AW+1:2] : r_word;
  assign w_ram_we = (r_state == ST_ACK) && r_we && !r_oor && !i_rst;

  serv_ram_bank #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .i_clk   (i_clk),
    .i_we    (w_ram_we),
    .i_be    (r_sel),
    .i_waddr (r_word),
    .i_wdat  (r_dat),
    .i_raddr (w_raddr),
    .o_rdat  (w_ram_q)
  );

  assign w_rd_word = r_oor ? '0 : w_ram_q;

  // ------------------------------------------------------ read data hold
  // Read data stays visible until the next read ack; writes leave it alone.
  always_ff @(posedge i_clk) begin
    if (i_rst)                                  r_rdt <= '0;
    else if ((r_state == ST_ACK) && !r_we)      r_rdt <= w_rd_word;
  end

endmodule

// File: tb/tb_serv_wb_mem_resp.sv
module tb_serv_wb_mem_resp;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [31:0] t_adr;
  logic [31:0] t_dat;
  logic [3:0]  t_sel;
  logic        t_we;
  logic        t_cyc;
  int          t_dut;

  serv_wb_mem_resp_if bus0 ();
  serv_wb_mem_resp_if bus3 ();
  serv_wb_mem_resp_if bus5 ();

  assign bus0.i_wb_adr = t_adr;
  assign bus0.i_wb_dat = t_dat;
  assign bus0.i_wb_sel = t_sel;
  assign bus0.i_wb_we  = t_we;
  assign bus0.i_wb_cyc = t_cyc && (t_dut == 0);
  assign bus3.i_wb_adr = t_adr;
  assign bus3.i_wb_dat = t_dat;
  assign bus3.i_wb_sel = t_sel;
  assign bus3.i_wb_we  = t_we;
  assign bus3.i_wb_cyc = t_cyc && (t_dut == 1);
  assign bus5.i_wb_adr = t_adr;
  assign bus5.i_wb_dat = t_dat;
  assign bus5.i_wb_sel = t_sel;
  assign bus5.i_wb_we  = t_we;
  assign bus5.i_wb_cyc = t_cyc && (t_dut == 2);

  serv_wb_mem_resp #(.DEPTH(256), .LAT(0)) u_dut0 (.i_clk(clk), .i_rst(rst), .bus(bus0));
  serv_wb_mem_resp #(.DEPTH(256), .LAT(3)) u_dut3 (.i_clk(clk), .i_rst(rst), .bus(bus3));
  serv_wb_mem_resp #(.DEPTH(256), .LAT(5)) u_dut5 (.i_clk(clk), .i_rst(rst), .bus(bus5));

  logic [31:0] o_rdt;
  logic        o_ack;
  logic        o_oor;

  always_comb begin
    o_rdt = bus0.o_wb_rdt;
    o_ack = bus0.o_wb_ack;
    o_oor = bus0.o_oor;
    case (t_dut)
      1: begin o_rdt = bus3.o_wb_rdt; o_ack = bus3.o_wb_ack; o_oor = bus3.o_oor; end
      2: begin o_rdt = bus5.o_wb_rdt; o_ack = bus5.o_wb_ack; o_oor = bus5.o_oor; end
      default: ;
    endcase
  end

  typedef struct {
    logic [31:0] rdt;
    logic        oor;
  } exp_t;

  exp_t        sbq[$];
  logic [31:0] mdl [3][256];
  logic [31:0] last_rdt [3];
  int          n_chk = 0;
  int          n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int lat_of(input int d);
    return (d == 0) ? 0 : ((d == 1) ? 3 : 5);
  endfunction

  task automatic drive(input logic [31:0] adr, input logic [31:0] dat,
                       input logic [3:0] sel, input logic we);
    t_adr = adr;
    t_dat = dat;
    t_sel = sel;
    t_we  = we;
    t_cyc = 1'b1;
  endtask

  // Called just after a rising edge; returns just after the edge that ends
  // the ack cycle, with cyc still high when hold is set.
  task automatic req(input string tag, input logic [31:0] adr, input logic [31:0] dat,
                     input logic [3:0] sel, input logic we, input bit hold);
    exp_t e;
    exp_t got_e;
    int   n;
    int   idx;
    drive(adr, dat, sel, we);
    idx   = int'(adr[9:2]);
    e.oor = (adr[31:10] != 22'd0);
    if (we) begin
      if (!e.oor) begin
        for (int k = 0; k < 4; k++)
          if (sel[k]) mdl[t_dut][idx][8*k +: 8] = dat[8*k +: 8];
      end
      e.rdt = last_rdt[t_dut];
    end else begin
      e.rdt = e.oor ? 32'd0 : mdl[t_dut][idx];
      last_rdt[t_dut] = e.rdt;
    end
    sbq.push_back(e);
    n = 0;
    forever begin
      @(negedge clk);
      if (o_ack) break;
      n++;
      if (n > 40) break;
      @(posedge clk);
      #1;
    end
    chk({tag, "_lat"}, 32'(n), 32'(lat_of(t_dut) + 1));
    if (o_ack) begin
      got_e = sbq.pop_front();
      chk({tag, "_rdt"}, o_rdt, got_e.rdt);
      chk({tag, "_oor"}, 32'(o_oor), 32'(got_e.oor));
    end
    @(posedge clk);
    #1;
    if (!hold) t_cyc = 1'b0;
  endtask

  task automatic idle_check(input string tag, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      chk(tag, 32'(o_ack), 32'd0);
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", n_err, n_chk);
    $fatal(1);
  end

  initial begin
    rst   = 1'b1;
    t_cyc = 1'b0;
    t_dut = 0;
    t_adr = '0;
    t_dat = '0;
    t_sel = '0;
    t_we  = 1'b0;
    for (int d = 0; d < 3; d++) last_rdt[d] = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state of all three responders
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      t_dut = d;
      #1;
      chk("rst_ack", 32'(o_ack), 32'd0);
      chk("rst_oor", 32'(o_oor), 32'd0);
      chk("rst_rdt", o_rdt, 32'd0);
    end
    t_dut = 0;
    @(posedge clk);
    #1;

    // LAT=0: basic write/read, byte lanes, sel=0, ignored offset bits
    req("wr0", 32'h10, 32'hDEADBEEF, 4'b1111, 1'b1, 1'b0);
    req("rd0", 32'h10, 32'h0, 4'b1111, 1'b0, 1'b0);
    @(negedge clk);
    chk("ackw0", 32'(o_ack), 32'd0);
    @(posedge clk);
    #1;
    req("wrl0", 32'h10, 32'h000000AA, 4'b0001, 1'b1, 1'b0);
    req("wrl2", 32'h10, 32'h00CC0000, 4'b0100, 1'b1, 1'b0);
    req("rdl",  32'h10, 32'h0, 4'b1111, 1'b0, 1'b0);
    chk("lanes", last_rdt[0], 32'hDECCBEAA);
    req("wrs0", 32'h10, 32'hFFFFFFFF, 4'b0000, 1'b1, 1'b0);
    req("rds0", 32'h13, 32'h0, 4'b1111, 1'b0, 1'b0);

    // Out of range
    req("wrw0",  32'h0,   32'h11111111, 4'b1111, 1'b1, 1'b0);
    req("wroor", 32'h400, 32'h55555555, 4'b1111, 1'b1, 1'b0);
    req("rdw0",  32'h0,   32'h0, 4'b1111, 1'b0, 1'b0);
    req("rdoor", 32'h400, 32'h0, 4'b1111, 1'b0, 1'b0);

    // Back-to-back with cyc held high
    req("b2bw0", 32'h0, 32'hA0A0A0A0, 4'b1111, 1'b1, 1'b1);
    req("b2bw1", 32'h4, 32'hB1B1B1B1, 4'b1111, 1'b1, 1'b1);
    req("b2bw2", 32'h8, 32'hC2C2C2C2, 4'b1111, 1'b1, 1'b1);
    req("b2br0", 32'h0, 32'h0, 4'b1111, 1'b0, 1'b1);
    req("b2br1", 32'h4, 32'h0, 4'b1111, 1'b0, 1'b1);
    req("b2br2", 32'h8, 32'h0, 4'b1111, 1'b0, 1'b1);
    req("rawwr", 32'hC, 32'h13579BDF, 4'b1111, 1'b1, 1'b1);
    req("rawrd", 32'hC, 32'h0, 4'b1111, 1'b0, 1'b0);

    // LAT=3: latency, ack width, abandoned write
    t_dut = 1;
    req("wr3", 32'h14, 32'h12345678, 4'b1111, 1'b1, 1'b0);
    req("rd3", 32'h14, 32'h0, 4'b1111, 1'b0, 1'b0);
    @(negedge clk);
    chk("ackw3", 32'(o_ack), 32'd0);
    @(posedge clk);
    #1;
    drive(32'h14, 32'hFFFFFFFF, 4'b1111, 1'b1);
    idle_check("ab3", 2);
    t_cyc = 1'b0;
    idle_check("ab3", 8);
    req("rdab3", 32'h14, 32'h0, 4'b1111, 1'b0, 1'b0);

    // LAT=5: reset while waiting
    t_dut = 2;
    req("wr5", 32'h1C, 32'hCAFEF00D, 4'b1111, 1'b1, 1'b0);
    drive(32'h1C, 32'h00000000, 4'b1111, 1'b1);
    idle_check("rst5", 3);
    rst = 1'b1;
    @(negedge clk);
    chk("rst5", 32'(o_ack), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int d = 0; d < 3; d++) last_rdt[d] = 32'd0;
    chk("rst5_rdt", o_rdt, 32'd0);
    req("rd5", 32'h1C, 32'h0, 4'b1111, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
